// File: rtl/core_lsu_bridge_pkg.sv
// Shared encodings for the core load/store bridge: access sizes, FSM states and the
// alignment rule that decides whether a request is rejected before touching memory.
package core_lsu_bridge_pkg;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        MERGE   = 3'd3,
        WR_REQ  = 3'd4,
        RESP    = 3'd5
    } lsu_state_e;

    // The reserved size encoding is rejected the same way as a misaligned access.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            LSU_SIZE_B: return 1'b0;
            LSU_SIZE_H: return addr_lo[0];
            LSU_SIZE_W: return addr_lo != 2'b00;
            default:    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/core_lsu_bridge_if.sv
// Core-side request/response and memory-side req/gnt/rvalid signals of the LSU bridge.
// The slave modport is the bridge; the master modport is the core plus data memory.
interface core_lsu_bridge_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  rsp_valid_o;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-3:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/core_lsu_align.sv
// Little-endian lane logic: extracts and extends a byte/half/word from a memory word and
// merges store data into the addressed lane of a word for read-modify-write stores.
module core_lsu_align
    import core_lsu_bridge_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = word[{addr_lo, 3'b000} +: 8];
    assign lane_h = word[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        load_data = word;
        merged    = word;
        case (size)
            LSU_SIZE_B: begin
                load_data = {{24{lane_b[7] & ~zext}}, lane_b};
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            LSU_SIZE_H: begin
                load_data = {{16{lane_h[15] & ~zext}}, lane_h};
                merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/core_lsu_bridge.sv
// Load/store bridge from the core data port to a word-wide memory without byte enables.
// Define CORE_LSU_LAST_WORD_BUF_EN to add a one-entry buffer of the last word read or written.
module core_lsu_bridge
    import core_lsu_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    core_lsu_bridge_if.slave  bus
);

    lsu_state_e            state, next_state;
    logic                  we_q, zext_q, rsp_valid_q, rsp_err_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] word_q, wr_word_q, rsp_rdata_q;
    logic                  accept, req_err, buf_hit;
    logic [DATA_WIDTH-1:0] src_word, load_data, merged;
    logic [1:0]            src_addr_lo, src_size;
    logic                  src_zext;

    assign accept  = (state == IDLE) && bus.req_valid_i;
    assign req_err = lsu_misaligned(bus.req_size_i, bus.req_addr_i[1:0]);

`ifdef CORE_LSU_LAST_WORD_BUF_EN
    logic                  buf_valid;
    logic [ADDR_WIDTH-3:0] buf_addr;
    logic [DATA_WIDTH-1:0] buf_data;

    // A full-word store always goes to memory; it refreshes the buffer on completion.
    assign buf_hit = buf_valid && (buf_addr == bus.req_addr_i[ADDR_WIDTH-1:2]) && !req_err &&
                     !(bus.req_we_i && (bus.req_size_i == LSU_SIZE_W));

    always_ff @(posedge clk) begin
        if (rst) buf_valid <= 1'b0;
        else if ((state == RD_WAIT && bus.mem_rvalid_i) || (state == WR_REQ && bus.mem_gnt_i))
            buf_valid <= 1'b1;
    end

    // NOTE: only the valid bit needs reset; address and data are never used while invalid.
    always_ff @(posedge clk) begin
        if (state == RD_WAIT && bus.mem_rvalid_i) begin
            buf_addr <= addr_q[ADDR_WIDTH-1:2];
            buf_data <= bus.mem_rdata_i;
        end else if (state == WR_REQ && bus.mem_gnt_i) begin
            buf_addr <= addr_q[ADDR_WIDTH-1:2];
            buf_data <= wr_word_q;
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    // Lane logic sees the request directly in IDLE (buffer hits), else the latched request.
    always_comb begin
        src_word    = (state == MERGE) ? word_q : bus.mem_rdata_i;
        src_addr_lo = addr_q[1:0];
        src_size    = size_q;
        src_zext    = zext_q;
`ifdef CORE_LSU_LAST_WORD_BUF_EN
        if (state == IDLE) begin
            src_word    = buf_data;
            src_addr_lo = bus.req_addr_i[1:0];
            src_size    = bus.req_size_i;
            src_zext    = bus.req_unsigned_i;
        end
`endif
    end

    core_lsu_align u_align (
        .word      (src_word),
        .addr_lo   (src_addr_lo),
        .size      (src_size),
        .zext      (src_zext),
        .wdata     (wr_word_q[15:0]),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.req_valid_i) begin
                if (req_err)                                          next_state = RESP;
                else if (buf_hit)                                     next_state = bus.req_we_i ? MERGE : RESP;
                else if (bus.req_we_i && bus.req_size_i == LSU_SIZE_W) next_state = WR_REQ;
                else                                                  next_state = RD_REQ;
            end
            RD_REQ:  if (bus.mem_gnt_i)    next_state = RD_WAIT;
            RD_WAIT: if (bus.mem_rvalid_i) next_state = we_q ? MERGE : RESP;
            MERGE:   next_state = WR_REQ;
            WR_REQ:  if (bus.mem_gnt_i)    next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_o = (state == IDLE);
        bus.mem_req_o   = (state == RD_REQ) || (state == WR_REQ);
        bus.mem_we_o    = (state == WR_REQ);
    end

    // Request fields and the write word hold still from acceptance until RESP.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            we_q        <= 1'b0;
            zext_q      <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            word_q      <= '0;
            wr_word_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= (next_state == RESP);
            rsp_err_q   <= accept && req_err;
            rsp_rdata_q <= '0;
            case (state)
                IDLE: if (accept) begin
                    we_q      <= bus.req_we_i;
                    zext_q    <= bus.req_unsigned_i;
                    size_q    <= bus.req_size_i;
                    addr_q    <= bus.req_addr_i;
                    wr_word_q <= bus.req_wdata_i;
                    if (buf_hit) begin
                        word_q <= src_word;
                        if (!bus.req_we_i) rsp_rdata_q <= load_data;
                    end
                end
                RD_WAIT: if (bus.mem_rvalid_i) begin
                    word_q <= bus.mem_rdata_i;
                    if (!we_q) rsp_rdata_q <= load_data;
                end
                MERGE:   wr_word_q <= merged;
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.mem_addr_o  = addr_q[ADDR_WIDTH-1:2];
    assign bus.mem_wdata_o = wr_word_q;

endmodule

// File: tb/tb_core_lsu_bridge.sv
// Directed bench for core_lsu_bridge with a req/gnt/rvalid memory model; expected latencies
// follow CORE_LSU_LAST_WORD_BUF_EN when the bench is built with it.
module tb_core_lsu_bridge;

`ifdef CORE_LSU_LAST_WORD_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif
    localparam int HIT_LAT  = BUF_EN ? 1 : 3;
    localparam int HIT_NREQ = BUF_EN ? 0 : 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_lsu_bridge_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();
    core_lsu_bridge #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: owned by the responder; tests only set the knobs below.
    logic [31:0] mem [0:1023];
    bit          mem_ready = 1'b0;
    int          req_cycles = 0, rd_cnt = 0, wr_cnt = 0, unstable_cnt = 0;
    bit          in_req = 1'b0, pend_rd = 1'b0;
    int          gnt_left = 0;
    logic [9:0]  pend_addr, snap_addr;
    logic        snap_we;
    logic [31:0] snap_wdata;
    int          gnt_delay = 0;
    bit          auto_rvalid = 1'b1;
    int          late_rv_cyc = -1;

    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
            mem[4] = 32'h8765_4321;
            mem[8] = 32'h1122_3344;
            mem_ready = 1'b1;
        end
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h5A5A_5A5A;
        if (pend_rd && auto_rvalid) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = mem[pend_addr];
        end
        pend_rd = 1'b0;
        if (cyc == late_rv_cyc) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 32'hBAD0_BAD0;
        end
        bus.mem_gnt_i = 1'b0;
        if (bus.mem_req_o === 1'b1) begin
            req_cycles++;
            if (!in_req) begin
                in_req = 1'b1;
                gnt_left = gnt_delay;
                snap_addr = bus.mem_addr_o;
                snap_we = bus.mem_we_o;
                snap_wdata = bus.mem_wdata_o;
            end else if ({bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o} !== {snap_addr, snap_we, snap_wdata}) begin
                unstable_cnt++;
            end
            if (gnt_left > 0) begin
                gnt_left--;
            end else begin
                bus.mem_gnt_i = 1'b1;
                in_req = 1'b0;
                if (bus.mem_we_o) begin
                    mem[bus.mem_addr_o] = bus.mem_wdata_o;
                    wr_cnt++;
                end else begin
                    pend_rd = 1'b1;
                    pend_addr = bus.mem_addr_o;
                    rd_cnt++;
                end
            end
        end
    end

    // One request; latency counts edges from the acceptance edge to the rsp_valid_o cycle.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int nreq, output bit hs_ok);
        int n0;
        @(negedge clk);
        hs_ok = bus.req_ready_o;
        n0 = req_cycles;
        bus.req_valid_i = 1'b1;
        bus.req_we_i = we;
        bus.req_size_i = size;
        bus.req_unsigned_i = uns;
        bus.req_addr_i = addr;
        bus.req_wdata_i = wdata;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        bus.req_we_i = ~we;
        bus.req_size_i = 2'b11;
        bus.req_unsigned_i = ~uns;
        bus.req_addr_i = 12'hFFF;
        bus.req_wdata_i = 32'hFFFF_FFFF;
        lat = -1;
        rdata = 32'hxxxx_xxxx;
        err = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.req_ready_o) hs_ok = 1'b0;
            if (bus.rsp_valid_o) begin
                lat = n;
                rdata = bus.rsp_rdata_o;
                err = bus.rsp_err_o;
                break;
            end
        end
        @(negedge clk);
        if (bus.rsp_valid_o || !bus.req_ready_o) hs_ok = 1'b0;
        nreq = req_cycles - n0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_we_i = 1'b0;
        bus.req_size_i = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i = 12'h0;
        bus.req_wdata_i = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.mem_req_o, bus.mem_we_o} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 10000", {bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.mem_req_o, bus.mem_we_o});
        end
        checks++;
        if (bus.rsp_rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h expected 00000000", bus.rsp_rdata_o);
        end
        checks++;
        if ({bus.mem_addr_o, bus.mem_wdata_o} !== 42'h0) begin
            failures++;
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0", bus.mem_addr_o, bus.mem_wdata_o);
        end
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  size;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] exp;
        int          lat;
        int          nreq;
    } ld_vec_t;

    task automatic test_loads();
        ld_vec_t v[6];
        int lat, nreq;
        logic [31:0] rd;
        logic err;
        bit hs;
        v[0] = '{2'b10, 1'b0, 12'h010, 32'h8765_4321, 3, 1};
        v[1] = '{2'b00, 1'b0, 12'h013, 32'hFFFF_FF87, HIT_LAT, HIT_NREQ};
        v[2] = '{2'b00, 1'b1, 12'h013, 32'h0000_0087, HIT_LAT, HIT_NREQ};
        v[3] = '{2'b01, 1'b0, 12'h012, 32'hFFFF_8765, HIT_LAT, HIT_NREQ};
        v[4] = '{2'b01, 1'b1, 12'h010, 32'h0000_4321, HIT_LAT, HIT_NREQ};
        v[5] = '{2'b00, 1'b0, 12'h010, 32'h0000_0021, HIT_LAT, HIT_NREQ};
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, v[i].size, v[i].uns, v[i].addr, 32'h0, lat, rd, err, nreq, hs);
            checks++;
            if (rd !== v[i].exp || err !== 1'b0) begin
                failures++;
                $display("FAIL load[%0d] data: got %h err=%b expected %h err=0", i, rd, err, v[i].exp);
            end
            checks++;
            if (lat !== v[i].lat || nreq !== v[i].nreq) begin
                failures++;
                $display("FAIL load[%0d] timing: got lat=%0d req=%0d expected lat=%0d req=%0d", i, lat, nreq, v[i].lat, v[i].nreq);
            end
            checks++;
            if (hs !== 1'b1) begin
                failures++;
                $display("FAIL load[%0d] handshake: got %b expected 1", i, hs);
            end
        end
    endtask

    task automatic test_store_sub();
        int lat, nreq, rd0, wr0;
        logic [31:0] rd;
        logic err;
        bit hs;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        do_req(1'b1, 2'b00, 1'b0, 12'h021, 32'hDEAD_BEAB, lat, rd, err, nreq, hs);
        checks++;
        if (mem[8] !== 32'h1122_AB44) begin
            failures++;
            $display("FAIL sb_word: got %h expected 1122ab44", mem[8]);
        end
        checks++;
        if (lat !== 5 || rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 1 || rd !== 32'h0 || err !== 1'b0 || hs !== 1'b1) begin
            failures++;
            $display("FAIL sb_flow: got lat=%0d rd=%0d wr=%0d rdata=%h err=%b hs=%b expected 5 1 1 0 0 1",
                     lat, rd_cnt - rd0, wr_cnt - wr0, rd, err, hs);
        end
        rd0 = rd_cnt;
        do_req(1'b1, 2'b01, 1'b0, 12'h022, 32'h0000_5566, lat, rd, err, nreq, hs);
        checks++;
        if (mem[8] !== 32'h5566_AB44) begin
            failures++;
            $display("FAIL sh_word: got %h expected 5566ab44", mem[8]);
        end
        checks++;
        if (lat !== (BUF_EN ? 3 : 5) || rd_cnt - rd0 !== (BUF_EN ? 0 : 1) || err !== 1'b0) begin
            failures++;
            $display("FAIL sh_flow: got lat=%0d reads=%0d err=%b expected %0d %0d 0",
                     lat, rd_cnt - rd0, err, BUF_EN ? 3 : 5, BUF_EN ? 0 : 1);
        end
    endtask

    task automatic test_misaligned();
        logic [1:0]  sz[4];
        logic [11:0] ad[4];
        logic        wv[4];
        int lat, nreq;
        logic [31:0] rd;
        logic err;
        bit hs;
        sz[0] = 2'b10; ad[0] = 12'h006; wv[0] = 1'b0;
        sz[1] = 2'b01; ad[1] = 12'h003; wv[1] = 1'b1;
        sz[2] = 2'b01; ad[2] = 12'h011; wv[2] = 1'b0;
        sz[3] = 2'b11; ad[3] = 12'h010; wv[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_req(wv[i], sz[i], 1'b0, ad[i], 32'h1234_5678, lat, rd, err, nreq, hs);
            checks++;
            if (err !== 1'b1 || lat !== 1 || rd !== 32'h0 || nreq !== 0 || hs !== 1'b1) begin
                failures++;
                $display("FAIL misalign[%0d]: got err=%b lat=%0d rdata=%h req=%0d hs=%b expected 1 1 0 0 1",
                         i, err, lat, rd, nreq, hs);
            end
        end
    endtask

    task automatic test_sw_stall();
        int lat, nreq, wr0, rd0, un0;
        logic [31:0] rd;
        logic err;
        bit hs;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        un0 = unstable_cnt;
        gnt_delay = 4;
        do_req(1'b1, 2'b10, 1'b0, 12'h030, 32'hCAFE_F00D, lat, rd, err, nreq, hs);
        gnt_delay = 0;
        checks++;
        if (lat !== 6 || nreq !== 5 || hs !== 1'b1) begin
            failures++;
            $display("FAIL sw_stall_timing: got lat=%0d req=%0d hs=%b expected 6 5 1", lat, nreq, hs);
        end
        checks++;
        if (unstable_cnt - un0 !== 0 || wr_cnt - wr0 !== 1 || rd_cnt - rd0 !== 0) begin
            failures++;
            $display("FAIL sw_stall_bus: got unstable=%0d writes=%0d reads=%0d expected 0 1 0",
                     unstable_cnt - un0, wr_cnt - wr0, rd_cnt - rd0);
        end
        checks++;
        if (mem[12] !== 32'hCAFE_F00D || rd !== 32'h0 || err !== 1'b0) begin
            failures++;
            $display("FAIL sw_stall_data: got mem=%h rdata=%h err=%b expected cafef00d 0 0", mem[12], rd, err);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nreq;
        logic [31:0] rd;
        logic err;
        bit hs;
        do_req(1'b1, 2'b10, 1'b0, 12'h040, 32'h0102_0304, lat, rd, err, nreq, hs);
        checks++;
        if (lat !== 2 || nreq !== 1 || mem[16] !== 32'h0102_0304) begin
            failures++;
            $display("FAIL b2b_sw: got lat=%0d req=%0d mem=%h expected 2 1 01020304", lat, nreq, mem[16]);
        end
        do_req(1'b0, 2'b10, 1'b1, 12'h040, 32'h0, lat, rd, err, nreq, hs);
        checks++;
        if (rd !== 32'h0102_0304 || lat !== HIT_LAT || nreq !== HIT_NREQ) begin
            failures++;
            $display("FAIL b2b_lw: got %h lat=%0d req=%0d expected 01020304 lat=%0d req=%0d", rd, lat, nreq, HIT_LAT, HIT_NREQ);
        end
        do_req(1'b0, 2'b00, 1'b0, 12'h041, 32'h0, lat, rd, err, nreq, hs);
        checks++;
        if (rd !== 32'h0000_0003 || lat !== HIT_LAT) begin
            failures++;
            $display("FAIL b2b_lb: got %h lat=%0d expected 00000003 lat=%0d", rd, lat, HIT_LAT);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nreq;
        logic [31:0] rd;
        logic err;
        bit hs, seen;
        auto_rvalid = 1'b0;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i = 1'b0;
        bus.req_size_i = 2'b10;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i = 12'h010;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        late_rv_cyc = cyc + 1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 10'h0) begin
            failures++;
            $display("FAIL reset_mid_abort: got rsp_seen=%b ready=%b mem_req=%b addr=%h expected 0 1 0 0",
                     seen, bus.req_ready_o, bus.mem_req_o, bus.mem_addr_o);
        end
        auto_rvalid = 1'b1;
        do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, lat, rd, err, nreq, hs);
        checks++;
        if (rd !== 32'h8765_4321 || lat !== 3 || nreq !== 1 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_lw: got %h lat=%0d req=%0d err=%b expected 87654321 3 1 0", rd, lat, nreq, err);
        end
        do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, lat, rd, err, nreq, hs);
        checks++;
        if (rd !== 32'h8765_4321 || lat !== HIT_LAT || nreq !== HIT_NREQ) begin
            failures++;
            $display("FAIL repeat_lw: got %h lat=%0d req=%0d expected 87654321 lat=%0d req=%0d", rd, lat, nreq, HIT_LAT, HIT_NREQ);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store_sub();
        test_misaligned();
        test_sw_stall();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/core_lsu_bridge.md
Name: core_lsu_bridge

Overview:
Load/store unit between the execution unit's data-memory port and a word-wide data memory with a request/grant/rvalid handshake and no byte enables. Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time and performs the memory accesses. Sub-word stores use read-modify-write. Returns sign- or zero-extended load data, or a misalignment error, with a one-cycle response pulse.

Parameters:
ADDR_WIDTH, 12, byte-address width of req_addr_i; the memory word address is ADDR_WIDTH-2 bits.
DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid_i  in  1  core request valid
req_ready_o  out  1  bridge can accept a request
req_we_i  in  1  1=store, 0=load
req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as error)
req_unsigned_i  in  1  zero-extend load (LBU/LHU)
req_addr_i  in  ADDR_WIDTH  byte address
req_wdata_i  in  DATA_WIDTH  store data, right-aligned
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and errors
rsp_err_o  out  1  misaligned or reserved size; valid with rsp_valid_o
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write
mem_addr_o  out  ADDR_WIDTH-2  word address = req_addr_i[ADDR_WIDTH-1:2]
mem_wdata_o  out  DATA_WIDTH  full write word
mem_gnt_i  in  1  memory accepted request
mem_rvalid_i  in  1  read data valid; may arrive 1 or more cycles after grant
mem_rdata_i  in  DATA_WIDTH  read word

Behaviour:
- Reset: on rst sampled high, the next state is IDLE.
  - Outputs after reset: req_ready_o=1; rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0; mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - Internal latches cleared.
  - Reset mid-operation aborts the transaction with no response. Any mem_rvalid_i arriving later in IDLE is ignored.
- Handshake:
  - req_ready_o=1 only in IDLE.
  - Accept when req_valid_i & req_ready_o. Latch we, size, unsigned, addr, wdata.
  - Request inputs are don't-care after acceptance.
- FSM states: IDLE, RD_REQ, RD_WAIT, MERGE, WR_REQ, RESP.
  - Error (half with addr[0]=1; word with addr[1:0]!=0; size=11): IDLE->RESP with rsp_err_o=1. No memory access.
  - Load: IDLE->RD_REQ (mem_req_o=1, mem_we_o=0; held until mem_gnt_i) -> RD_WAIT (until mem_rvalid_i; capture word) -> RESP.
  - SW: IDLE->WR_REQ (mem_req_o=1, mem_we_o=1, mem_wdata_o=wdata; held until mem_gnt_i) -> RESP.
  - SB/SH: IDLE->RD_REQ->RD_WAIT->MERGE->WR_REQ->RESP.
    - MERGE replaces byte lane addr[1:0] (SB) or half lane addr[1] (SH) of the read word with wdata[7:0] or wdata[15:0].
  - RESP: rsp_valid_o=1 for exactly one cycle, then IDLE.
- Memory-side rules:
  - mem_addr_o, mem_we_o and mem_wdata_o are stable while mem_req_o=1 and mem_gnt_i=0.
  - mem_req_o deasserts in the cycle after grant.
  - Grant in the same cycle the request is raised is legal.
- Load extraction (little-endian):
  - Byte = word[8*addr[1:0]+:8].
  - Half = word[16*addr[1]+:16].
  - Sign-extend unless req_unsigned_i; req_unsigned_i is ignored for word loads.
- Latency with zero-wait memory (gnt same cycle, rvalid next cycle), counted from acceptance edge to rsp_valid_o: SW 2 cycles, load 3, SB/SH 5, error 1.
- All registered outputs change only on clk rising edge. rsp_* are registered.

Optional Feature:
Macro CORE_LSU_LAST_WORD_BUF_EN.
- Defined: a one-entry buffer holds {valid, word address, data} of the last word read or written.
  - Load hit: IDLE->RESP directly (latency 1) with no memory access.
  - SB/SH hit: skips RD_REQ/RD_WAIT and merges from the buffer.
  - Every completed write updates the buffer.
  - Reset clears valid.
- Undefined: no buffer; every access goes to memory as above.

Decomposition:
- Shared package/defines header:
  - size encodings (LSU_SIZE_B/H/W)
  - FSM state encoding (3-bit)
  - misalignment check function
- Sub-module core_lsu_align: purely combinational.
  - Load extract/extend and store lane merge.
  - Keeps the FSM file focused on sequencing.

Test Plan:
- LW addr 0x010, memory word 0x8765_4321, zero-wait -> rsp_valid_o 3 cycles after accept, rsp_rdata_o=0x8765_4321, err=0.
- LB addr 0x013 (word 0x8765_4321) -> 0xFFFF_FF87. LBU same address -> 0x0000_0087. LH addr 0x012 -> 0xFFFF_8765.
- SB addr 0x021, wdata 0xAB, existing word 0x1122_3344 -> one read of word 0x08, then write 0x1122_AB44, rsp after 5 cycles.
- LW addr 0x006 or SH addr 0x003 -> rsp_err_o=1 after 1 cycle, mem_req_o never asserted.
- SW with mem_gnt_i held low 4 cycles -> mem_req_o, mem_addr_o and mem_wdata_o stable throughout; single write; req_ready_o=0 until after RESP.
- rst pulsed in RD_WAIT, then late mem_rvalid_i -> no rsp_valid_o; next request processed normally.
  - With CORE_LSU_LAST_WORD_BUF_EN: repeat the LW to 0x010 -> latency 1, no mem_req_o.
